// File: rtl/uart_result_tx.sv
// Result-byte UART transmitter: FIFO_DEPTH-entry byte FIFO feeding an 8N1 serialiser, or 8E1 when UART_TX_PARITY_EN is defined.
// Pops one edge after a byte lands in an empty FIFO; tx_ready drops while the FIFO is full.
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              rdy_en_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic push, pop, baud_end;

  // rdy_en_q holds tx_ready low through reset and releases it on the first edge after.
  assign tx_ready = rdy_en_q && (count_q != FULL_CNT);
  assign busy     = (state_q != IDLE) || (count_q != '0);
  assign uart_txd = txd_q;

  always_comb begin
    push      = tx_valid && tx_ready;
    pop       = 1'b0;
    baud_end  = (baud_q == BAUD_LAST);
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    baud_d    = baud_end ? '0 : baud_q + 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (count_q != '0) pop = 1'b1;
      end
      START: begin
        if (baud_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        // Chaining straight into the next START keeps back-to-back frames gap-free.
        if (baud_end) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (pop) begin
      state_d   = START;
      shift_d   = mem_q[rd_ptr_q];
      txd_d     = 1'b0;
      baud_d    = '0;
      bit_idx_d = '0;
      rd_ptr_d  = rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^mem_q[rd_ptr_q];
`endif
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      rdy_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      rdy_en_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4; honours UART_TX_PARITY_EN.
module tb_uart_result_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       busy;

  int errors = 0;
  int checks = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  uart_result_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_txd(uart_txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Line decoder: samples mid-bit on falling edges, collects bytes, counts framing/parity errors.
  logic [7:0] rx_q[$];
  int         rx_idx = -1;
  int         rx_j;
  int         rx_ferr = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_idx = -1;
    end else if (rx_idx < 0) begin
      if (uart_txd === 1'b0) rx_idx = 1;
    end else if (rx_idx % 4 == 2) begin
      rx_j = rx_idx / 4;
      if (rx_j == 0) begin
        if (uart_txd !== 1'b0) rx_ferr++;
      end else if (rx_j <= 8) begin
        rx_byte[rx_j-1] = uart_txd;
      end else if (rx_j == 9 && NB == 11) begin
        rx_par = uart_txd;
      end
      if (rx_j == NB - 1) begin
        if (uart_txd !== 1'b1) rx_ferr++;
        if (NB == 11 && rx_par !== ^rx_byte) rx_ferr++;
        rx_q.push_back(rx_byte);
        rx_idx = -1;
      end else begin
        rx_idx++;
      end
    end else begin
      rx_idx++;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic [9:0] f;   // {stop, d7..d0, start}, line order from bit 0
    logic       p;   // even parity of d
  } vec_t;
  vec_t vt[8];

  function automatic logic [10:0] line_bits(input vec_t v);
    if (NB == 11) return {1'b1, v.p, v.f[8:0]};
    return {1'b0, v.f};
  endfunction

  // Caller sits on the falling edge just after the START-entry edge; one check per bit period.
  task automatic check_frame(input string name, input logic [10:0] exp);
    for (int b = 0; b < NB; b++) begin
      logic [3:0] got;
      for (int c = 0; c < 4; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        got[c] = uart_txd;
      end
      chk($sformatf("%s bit%0d", name, b), int'(got), exp[b] ? 15 : 0);
    end
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk1({name, " idle"}, busy, 1'b0);
  endtask

  logic [7:0] wb[10];

  initial begin
    vt[0] = '{8'h3E, 10'b1_00111110_0, 1'b1};
    vt[1] = '{8'h05, 10'b1_00000101_0, 1'b0};
    vt[2] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vt[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vt[4] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vt[5] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vt[6] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vt[7] = '{8'h80, 10'b1_10000000_0, 1'b1};
    wb = '{8'h3E, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h7E, 8'hC3, 8'h3C};

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst txd", uart_txd, 1'b1);
    chk1("rst busy", busy, 1'b0);
    chk1("rst ready", tx_ready, 1'b0);
    rst_n = 1'b1;
    #1 chk1("ready before first edge", tx_ready, 1'b0);
    @(negedge clk);
    chk1("ready after first edge", tx_ready, 1'b1);

    // Single-byte frames from the table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_data = vt[i].d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk1($sformatf("v%0d txd at accept", i), uart_txd, 1'b1);
      chk1($sformatf("v%0d busy at accept", i), busy, 1'b1);
      @(negedge clk);
      check_frame($sformatf("v%0d", i), line_bits(vt[i]));
      chk1($sformatf("v%0d busy last cycle", i), busy, 1'b1);
      @(negedge clk);
      chk1($sformatf("v%0d busy after frame", i), busy, 1'b0);
      chk1($sformatf("v%0d txd after frame", i), uart_txd, 1'b1);
    end
    chk("table rx count", rx_q.size(), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk($sformatf("table rx byte %0d", i), int'(rx_q[i]), int'(vt[i].d));

    // Back-to-back: STOP of frame 1 runs straight into START of frame 2
    rx_q.delete();
    @(negedge clk);
    tx_data = 8'h05;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hA5;
    chk1("b2b txd at accept", uart_txd, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame("b2b f1", line_bits(vt[1]));
    @(negedge clk);
    check_frame("b2b f2", line_bits(vt[2]));
    @(negedge clk);
    chk1("b2b busy after two frames", busy, 1'b0);

    // Full FIFO: sixth byte arrives while full and is dropped
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) chk1("full ready before 5th", tx_ready, 1'b1);
      if (i == 5) chk1("full ready low", tx_ready, 1'b0);
      tx_data = 8'(i + 1);
      tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle("full", 600);
    chk("full rx count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk($sformatf("full rx byte %0d", i), int'(rx_q[i]), i + 1);

    // Reset during DATA bit 3 of 0xFF with two bytes queued
    rx_q.delete();
    @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h11;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk1("midrst busy before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("midrst txd", uart_txd, 1'b1);
    chk1("midrst busy", busy, 1'b0);
    chk1("midrst ready", tx_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      int lows = 0;
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        if (uart_txd !== 1'b1) lows++;
      end
      chk("midrst line low cycles", lows, 0);
    end
    chk("midrst rx count", rx_q.size(), 0);
    chk1("midrst busy after", busy, 1'b0);
    chk1("midrst ready after", tx_ready, 1'b1);

    // Wrap-around: ten bytes, tx_valid gated by tx_ready
    rx_q.delete();
    begin
      int i = 0;
      int guard = 0;
      while (i < 10 && guard < 2000) begin
        @(negedge clk);
        guard++;
        if (tx_ready) begin
          tx_data = wb[i];
          tx_valid = 1'b1;
          i++;
        end else begin
          tx_valid = 1'b0;
        end
      end
      @(negedge clk);
      tx_valid = 1'b0;
      chk("wrap bytes offered", i, 10);
    end
    wait_idle("wrap", 800);
    chk("wrap rx count", rx_q.size(), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      chk($sformatf("wrap rx byte %0d", i), int'(rx_q[i]), int'(wb[i]));

    chk("line framing errors", rx_ferr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
